// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared constants for the pipeline hazard / control-flow
//                controller: FSM state encoding, stage indices, default PC
//                width and the shadow-counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    // FSM encoding, explicit width so it matches legacy 2-bit state buses
    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_BR_SHADOW = 2'd1;
    localparam state_t ST_EXC_REDIR = 2'd2;

    // Stage indices for the classic 5-stage configuration
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // Default PC width
    localparam int DEF_ADDR_W = 32;

    // Shadow counter holds 0..3
    localparam int SHADOW_CNT_W = 2;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/branch_shadow_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : branch_shadow_cnt
//  Description : Branch-shadow down-counter. Loads a fixed value on a branch
//                accept, decrements each unfrozen cycle, clears on exception.
//                o_active is high while the count is non-zero, o_last while
//                the count equals one.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_shadow_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W    = SHADOW_CNT_W,
    parameter int LOAD_VAL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_freeze,
    input  logic i_clear,
    output logic o_active,
    output logic o_last
);

    logic [CNT_W-1:0] r_cnt;

    // Clear has priority over load; a frozen counter holds its value
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(LOAD_VAL);
        end else if ((r_cnt != '0) && !i_freeze) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_active = (r_cnt != '0);
    assign o_last   = (r_cnt == CNT_W'(1));

endmodule : branch_shadow_cnt
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Parametrised pipeline hazard and control-flow controller.
//                Produces per-stage stall/flush vectors from stall requests,
//                branch redirects (with a configurable flush shadow) and
//                exception flushes, plus a single PC redirect port.
//                Optional macro PIPE_CTRL_PERF_EN adds saturating stall-cycle
//                and flush-event counters.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES    = 5,
    parameter int BR_STAGE      = STG_EX,
    parameter int BR_SHADOW_CYC = 1,
    parameter int ADDR_W        = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stall_req_i,
    input  logic                  branch_i,
    input  logic [ADDR_W-1:0]     branch_target_i,
    input  logic                  excp_i,
    input  logic [ADDR_W-1:0]     excp_target_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  redirect_valid_o,
    output logic [ADDR_W-1:0]     redirect_pc_o,
    output logic                  busy_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cyc_o,
    output logic [31:0]           perf_flush_evt_o
`endif
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_excp_target;

    logic [NUM_STAGES-1:0] w_stall_raw;
    logic [NUM_STAGES-1:0] w_flush;
    logic                  w_redirect_valid;
    logic [ADDR_W-1:0]     w_redirect_pc;
    logic                  w_br_accept;
    logic                  w_shadow_load;
    logic                  w_freeze;
    logic                  w_shadow_active;
    logic                  w_shadow_last;

    // A stall at stage j back-pressures every stage upstream of it
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stall
            assign w_stall_raw[gi] = |stall_req_i[NUM_STAGES-1:gi];
        end
    endgenerate

    // Branches are only taken from IDLE: shadow-slot branches are bogus and
    // an exception always wins
    assign w_br_accept   = (r_state == ST_IDLE) && !excp_i && branch_i
                           && !w_stall_raw[BR_STAGE];
    assign w_shadow_load = w_br_accept && (BR_SHADOW_CYC > 0);
    assign w_freeze      = |stall_req_i;

    branch_shadow_cnt #(
        .CNT_W    (SHADOW_CNT_W),
        .LOAD_VAL (BR_SHADOW_CYC)
    ) u_shadow_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_shadow_load),
        .i_freeze (w_freeze),
        .i_clear  (excp_i),
        .o_active (w_shadow_active),
        .o_last   (w_shadow_last)
    );

    // Control FSM: exceptions preempt everything, shadow exits on its last
    // unfrozen cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (excp_i) begin
            r_state <= ST_EXC_REDIR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_shadow_load) r_state <= ST_BR_SHADOW;
                end
                ST_BR_SHADOW: begin
                    if (!w_shadow_active || (w_shadow_last && !w_freeze)) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXC_REDIR: r_state <= ST_IDLE;
                default:      r_state <= ST_IDLE;
            endcase
        end
    end

    // Capture the handler PC so the redirect is issued one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_excp_target <= '0;
        end else if (excp_i) begin
            r_excp_target <= excp_target_i;
        end
    end

    // Flush / redirect arbitration in precedence order
    always_comb begin
        w_flush          = '0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;
        if (rst) begin
            w_flush = '1;
        end else if (r_state == ST_EXC_REDIR) begin
            w_flush          = '1;
            w_redirect_valid = 1'b1;
            w_redirect_pc    = r_excp_target;
        end else if (excp_i) begin
            w_flush = '1;
        end else if (r_state == ST_BR_SHADOW) begin
            w_flush[BR_STAGE-1] = 1'b1;
        end else if (w_br_accept) begin
            for (int i = 0; i < BR_STAGE; i++) begin
                w_flush[i] = 1'b1;
            end
            w_redirect_valid = 1'b1;
            w_redirect_pc    = branch_target_i;
        end
    end

    // A flushed stage turns into a bubble, so its stall is dropped
    assign stall_o          = w_stall_raw & ~w_flush;
    assign flush_o          = w_flush;
    assign redirect_valid_o = w_redirect_valid;
    assign redirect_pc_o    = w_redirect_pc;
    assign busy_o           = !rst && (r_state != ST_IDLE);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (stall_o[0] && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if ((w_br_accept || excp_i) && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_cyc_o = r_perf_stall;
    assign perf_flush_evt_o = r_perf_flush;
`endif

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl. Directed scenarios then
//                randomized traffic, compared each cycle against a
//                behavioural model of the controller rules.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipe_ctrl;

    localparam int NS = 5;
    localparam int BR = 2;
    localparam int SH = 1;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] stall_req_i;
    logic          branch_i;
    logic [AW-1:0] branch_target_i;
    logic          excp_i;
    logic [AW-1:0] excp_target_i;
    logic [NS-1:0] stall_o;
    logic [NS-1:0] flush_o;
    logic          redirect_valid_o;
    logic [AW-1:0] redirect_pc_o;
    logic          busy_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]   perf_stall_cyc_o;
    logic [31:0]   perf_flush_evt_o;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(
        .NUM_STAGES    (NS),
        .BR_STAGE      (BR),
        .BR_SHADOW_CYC (SH),
        .ADDR_W        (AW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_req_i      (stall_req_i),
        .branch_i         (branch_i),
        .branch_target_i  (branch_target_i),
        .excp_i           (excp_i),
        .excp_target_i    (excp_target_i),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .busy_o           (busy_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cyc_o (perf_stall_cyc_o),
        .perf_flush_evt_o (perf_flush_evt_o)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Model: pending exception redirect, remaining shadow cycles, saved PC
    bit            m_exc_pend;
    int            m_shadow;
    logic [AW-1:0] m_exc_pc;
    longint        m_perf_stall;
    longint        m_perf_flush;

    logic [NS-1:0] e_stall;
    logic [NS-1:0] e_flush;
    bit            e_rv;
    logic [AW-1:0] e_pc;
    bit            e_busy;
    bit            e_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        logic [NS-1:0] raw;
        raw = '0;
        for (int i = 0; i < NS; i++)
            for (int j = i; j < NS; j++)
                if (stall_req_i[j]) raw[i] = 1'b1;
        e_flush = '0; e_rv = 0; e_pc = '0; e_acc = 0;
        if (rst) begin
            e_flush = '1;
        end else if (m_exc_pend) begin
            e_flush = '1; e_rv = 1; e_pc = m_exc_pc;
        end else if (excp_i) begin
            e_flush = '1;
        end else if (m_shadow > 0) begin
            e_flush[BR-1] = 1'b1;
        end else if (branch_i && !raw[BR]) begin
            for (int i = 0; i < BR; i++) e_flush[i] = 1'b1;
            e_rv = 1; e_pc = branch_target_i; e_acc = 1;
        end
        e_stall = raw & ~e_flush;
        e_busy  = !rst && (m_exc_pend || m_shadow > 0);
    endtask

    task automatic model_update();
        if (rst) begin
            m_exc_pend = 0; m_shadow = 0; m_exc_pc = '0;
            m_perf_stall = 0; m_perf_flush = 0;
        end else begin
            if (e_stall[0] && m_perf_stall < 64'hFFFF_FFFF) m_perf_stall++;
            if ((e_acc || excp_i) && m_perf_flush < 64'hFFFF_FFFF) m_perf_flush++;
            if (excp_i) begin
                m_exc_pend = 1; m_exc_pc = excp_target_i; m_shadow = 0;
            end else if (m_exc_pend) begin
                m_exc_pend = 0;
            end else if (m_shadow > 0) begin
                if (stall_req_i == '0) m_shadow--;
            end else if (e_acc) begin
                m_shadow = SH;
            end
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model,
    // then advance the model to the state after the coming edge
    task automatic cyc(input bit r, input logic [NS-1:0] req, input bit br,
                       input logic [AW-1:0] bt, input bit ex, input logic [AW-1:0] et);
        @(negedge clk);
        rst = r; stall_req_i = req; branch_i = br; branch_target_i = bt;
        excp_i = ex; excp_target_i = et;
        #1;
        model_eval();
        check("stall_o", 64'(stall_o), 64'(e_stall));
        check("flush_o", 64'(flush_o), 64'(e_flush));
        check("redirect_valid_o", 64'(redirect_valid_o), 64'(e_rv));
        check("redirect_pc_o", 64'(redirect_pc_o), 64'(e_pc));
        check("busy_o", 64'(busy_o), 64'(e_busy));
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall_cyc_o", 64'(perf_stall_cyc_o), 64'(m_perf_stall));
        check("perf_flush_evt_o", 64'(perf_flush_evt_o), 64'(m_perf_flush));
`endif
        model_update();
    endtask

    initial begin
        logic [NS-1:0] rq;
        rst = 1; stall_req_i = '0; branch_i = 0; branch_target_i = '0;
        excp_i = 0; excp_target_i = '0;
        m_exc_pend = 0; m_shadow = 0; m_exc_pc = '0; m_perf_stall = 0; m_perf_flush = 0;

        // Reset held three cycles
        for (int k = 0; k < 3; k++) begin
            cyc(1, '0, 0, '0, 0, '0);
            check("rst_flush", 64'(flush_o), 64'h1F);
            check("rst_stall", 64'(stall_o), 64'h0);
            check("rst_rv", 64'(redirect_valid_o), 64'h0);
        end
        cyc(0, '0, 0, '0, 0, '0);
        check("post_rst_busy", 64'(busy_o), 64'h0);
        check("post_rst_flush", 64'(flush_o), 64'h0);

        // Stall back-pressure
        cyc(0, 5'b01000, 0, '0, 0, '0);
        check("stall_bp", 64'(stall_o), 64'h0F);
        check("stall_noflush", 64'(flush_o), 64'h0);
        cyc(0, '0, 0, '0, 0, '0);
        check("stall_release", 64'(stall_o), 64'h0);

        // Branch with one shadow cycle
        cyc(0, '0, 1, 32'h1c00_0100, 0, '0);
        check("br_flush", 64'(flush_o), 64'h03);
        check("br_pc", 64'(redirect_pc_o), 64'h1c00_0100);
        check("br_rv", 64'(redirect_valid_o), 64'h1);
        cyc(0, '0, 0, '0, 0, '0);
        check("shadow_flush", 64'(flush_o), 64'h02);
        check("shadow_busy", 64'(busy_o), 64'h1);
        cyc(0, '0, 0, '0, 0, '0);
        check("shadow_done_flush", 64'(flush_o), 64'h0);
        check("shadow_done_busy", 64'(busy_o), 64'h0);

        // Exception beats branch
        cyc(0, '0, 1, 32'h1c00_0200, 1, 32'h1c00_8000);
        check("excbr_flush", 64'(flush_o), 64'h1F);
        check("excbr_rv", 64'(redirect_valid_o), 64'h0);
        cyc(0, '0, 0, '0, 0, '0);
        check("exc_rv", 64'(redirect_valid_o), 64'h1);
        check("exc_pc", 64'(redirect_pc_o), 64'h1c00_8000);
        cyc(0, '0, 0, '0, 0, '0);
        check("exc_idle", 64'(busy_o), 64'h0);

        // Exception inside the branch shadow
        cyc(0, '0, 1, 32'h1c00_0300, 0, '0);
        cyc(0, '0, 0, '0, 1, 32'h1c00_9000);
        check("excsh_flush", 64'(flush_o), 64'h1F);
        cyc(0, '0, 0, '0, 0, '0);
        check("excsh_redir", 64'(redirect_pc_o), 64'h1c00_9000);
        cyc(0, '0, 0, '0, 0, '0);
        check("excsh_idle", 64'(busy_o), 64'h0);
        check("excsh_noflush", 64'(flush_o), 64'h0);

        // Stalled branch waits for the stall to drop
        cyc(0, 5'b01000, 1, 32'h1c00_0400, 0, '0);
        check("stbr_norv", 64'(redirect_valid_o), 64'h0);
        cyc(0, '0, 1, 32'h1c00_0400, 0, '0);
        check("stbr_rv", 64'(redirect_valid_o), 64'h1);
        // Shadow frozen by a stall request
        cyc(0, 5'b00001, 0, '0, 0, '0);
        cyc(0, '0, 0, '0, 0, '0);
        check("frz_flush", 64'(flush_o), 64'h02);
        cyc(0, '0, 0, '0, 0, '0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rq = '0;
            for (int b = 0; b < NS; b++) rq[b] = ($urandom_range(5) == 0);
            cyc(($urandom_range(99) == 0), rq, ($urandom_range(2) == 0), $urandom,
                ($urandom_range(11) == 0), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pipe_ctrl
`default_nettype wire
